// File: rtl/svd_pkg.sv
// rtl/svd_pkg.sv - shared types and constants for the SVD load/read sequencer (ERR state exists only with SVD_SEQ_TIMEOUT_EN)
package svd_pkg;

    localparam int DATA_W = 10;
    localparam int HALF_W = 5;
    localparam int UV_W   = 8;
    localparam int S_W    = 7;
    localparam int N_ELEM = 4;

    // WAIT gives up after this many cycles without svd_ready
    localparam int         TIMEOUT_CYC  = 256;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_READ,
        ST_DONE
`ifdef SVD_SEQ_TIMEOUT_EN
        , ST_ERR
`endif
    } state_e;

endpackage

// File: rtl/svd_seq_timer.sv
// rtl/svd_seq_timer.sv - 8-bit WAIT-state cycle counter, used only with SVD_SEQ_TIMEOUT_EN
module svd_seq_timer
    import svd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    // Count while enabled; any cycle outside WAIT clears the count
    always_comb begin
        cnt_d = en_i ? cnt_q + 8'd1 : 8'd0;
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == TIMEOUT_LAST);

endmodule

// File: rtl/svd_seq.sv
// rtl/svd_seq.sv - SVD core load/wait/read sequencer; SVD_SEQ_TIMEOUT_EN adds WAIT timeout, ERR state and err port
module svd_seq
    import svd_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_ELEM*DATA_W-1:0]   mat_i,
    output logic                       busy,
    output logic                       done,
    output logic [N_ELEM*UV_W-1:0]     uv_o,
    output logic [N_ELEM*S_W-1:0]      s_o,
    output logic                       svd_we,
    output logic                       svd_oe,
    output logic [HALF_W-1:0]          svd_data,
    output logic [1:0]                 svd_sel,
    input  logic                       svd_ready,
    input  logic [UV_W-1:0]            svd_uv,
    input  logic [S_W-1:0]             svd_s
`ifdef SVD_SEQ_TIMEOUT_EN
    ,
    output logic                       err
`endif
);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   mat_q [N_ELEM];
    logic [UV_W-1:0]     uv_q  [N_ELEM];
    logic [S_W-1:0]      s_q   [N_ELEM];
    logic [DATA_W-1:0]   elem;
    logic                latch;
    logic                cap;
    logic                tmo_expired;

    // cnt_q[2:1] is the element index in both LOAD and READ; cnt_q[0] picks the half/second cycle
    assign elem = mat_q[cnt_q[2:1]];

`ifdef SVD_SEQ_TIMEOUT_EN
    logic err_q;

    svd_seq_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ST_WAIT),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // Next-state and core-interface decode; READ starts its count at 15 so the settle cycle precedes element 0
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        svd_we   = 1'b0;
        svd_oe   = 1'b0;
        svd_sel  = 2'd0;
        svd_data = '0;
        done     = 1'b0;
        latch    = 1'b0;
        cap      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (start) begin
                    latch   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                svd_we   = 1'b1;
                svd_sel  = cnt_q[2:1];
                svd_data = cnt_q[0] ? elem[DATA_W-1:HALF_W] : elem[HALF_W-1:0];
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = 4'd1;
                if (cnt_q != 4'd0 && svd_ready) begin
                    cnt_d   = 4'hF;
                    state_d = ST_READ;
                end
`ifdef SVD_SEQ_TIMEOUT_EN
                else if (tmo_expired) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ERR;
                end
`endif
            end
            ST_READ: begin
                svd_oe = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q != 4'hF) begin
                    svd_sel = cnt_q[2:1];
                    cap     = cnt_q[0];
                end
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef SVD_SEQ_TIMEOUT_EN
            ST_ERR: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and sequence counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Matrix latch on accepted start and result capture on each element's second read cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_ELEM; k++) begin
                mat_q[k] <= '0;
                uv_q[k]  <= '0;
                s_q[k]   <= '0;
            end
        end else begin
            if (latch) begin
                for (int k = 0; k < N_ELEM; k++) mat_q[k] <= mat_i[k*DATA_W +: DATA_W];
            end
            if (cap) begin
                uv_q[cnt_q[2:1]] <= svd_uv;
                s_q[cnt_q[2:1]]  <= svd_s;
            end
        end
    end

`ifdef SVD_SEQ_TIMEOUT_EN
    // Sticky error flag: set on timeout, cleared by the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    err_q <= 1'b0;
        else if (latch)             err_q <= 1'b0;
        else if (state_d == ST_ERR) err_q <= 1'b1;
    end

    assign err = err_q;
`endif

    assign busy = (state_q != ST_IDLE);
    assign uv_o = {uv_q[3], uv_q[2], uv_q[1], uv_q[0]};
    assign s_o  = {s_q[3], s_q[2], s_q[1], s_q[0]};

endmodule
